// File: rtl/axis_frame_packer_if.sv
// AXI-Stream sample bus between the upstream sample source and the frame packer.
interface axis_frame_packer_if #(
   parameter int unsigned DW = 16
);
   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          tlast;
   logic          tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_frame_packer.sv
// Write-side front end of the async stream FIFO: packs samples into fixed-length
// frames, tags end-of-frame in din[DW], and drops whole frames when the FIFO is nearly full.
module axis_frame_packer #(
   parameter int unsigned DW        = 16,
   parameter int unsigned FRAME_LEN = 64,
   parameter int unsigned IDXW      = 6,
   parameter int unsigned CNTW      = 16
) (
   input  logic                 wr_clk,
   input  logic                 wrstn_c,
   input  logic                 en,
   axis_frame_packer_if.slave   s_axis,
   input  logic                 q_afull,
   input  logic                 qfull,
   output logic                 push,
   output logic [DW:0]          din,
   output logic [IDXW-1:0]      wr_index,
   output logic [CNTW-1:0]      frame_cnt,
   output logic [CNTW-1:0]      drop_cnt,
   output logic                 ovf_err
);

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(FRAME_LEN - 1);

   typedef enum logic [1:0] {IDLE, FILL, DROP} state_e;

   state_e            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              push_q, push_d;
   logic [DW:0]       din_q, din_d;
   logic [CNTW-1:0]   fcnt_q, fcnt_d;
   logic [CNTW-1:0]   dcnt_q, dcnt_d;
   logic              ovf_q, ovf_d;
   logic              tready_c;
   logic              acc_c;
   logic              eof_c;

   // Ready is a function of state, en and q_afull only; held low while in reset.
   always_comb begin
      tready_c = 1'b0;
      unique case (state_q)
         IDLE:    tready_c = en;
         FILL:    tready_c = !q_afull;
         DROP:    tready_c = 1'b1;
         default: tready_c = 1'b0;
      endcase
      tready_c = tready_c & wrstn_c;
   end

   assign s_axis.tready = tready_c;
   assign acc_c         = s_axis.tvalid & tready_c;
   assign eof_c         = (idx_q == LAST_IDX) | s_axis.tlast;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      push_d  = 1'b0;
      din_d   = din_q;
      fcnt_d  = fcnt_q;
      dcnt_d  = dcnt_q;
      ovf_d   = ovf_q | (push_q & qfull);

      unique case (state_q)
         IDLE: begin
            // Frame start: the write/drop decision is made once, here.
            if (acc_c) begin
               if (!q_afull) begin
                  push_d = 1'b1;
                  din_d  = {eof_c, s_axis.tdata};
                  if (eof_c) begin
                     fcnt_d = fcnt_q + 1'b1;
                  end else begin
                     state_d = FILL;
                     idx_d   = IDXW'(1);
                  end
               end else begin
                  if (eof_c) begin
                     dcnt_d = (dcnt_q == '1) ? dcnt_q : dcnt_q + 1'b1;
                  end else begin
                     state_d = DROP;
                     idx_d   = IDXW'(1);
                  end
               end
            end
         end
         FILL: begin
            if (acc_c) begin
               push_d = 1'b1;
               din_d  = {eof_c, s_axis.tdata};
               if (eof_c) begin
                  fcnt_d  = fcnt_q + 1'b1;
                  idx_d   = '0;
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         DROP: begin
            if (acc_c) begin
               if (eof_c) begin
                  dcnt_d  = (dcnt_q == '1) ? dcnt_q : dcnt_q + 1'b1;
                  idx_d   = '0;
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge wr_clk or negedge wrstn_c) begin
      if (!wrstn_c) begin
         state_q <= IDLE;
         idx_q   <= '0;
         push_q  <= 1'b0;
         din_q   <= '0;
         fcnt_q  <= '0;
         dcnt_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         push_q  <= push_d;
         din_q   <= din_d;
         fcnt_q  <= fcnt_d;
         dcnt_q  <= dcnt_d;
         ovf_q   <= ovf_d;
      end
   end

   assign push      = push_q;
   assign din       = din_q;
   assign wr_index  = idx_q;
   assign frame_cnt = fcnt_q;
   assign drop_cnt  = dcnt_q;
   assign ovf_err   = ovf_q;

endmodule
